// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch-side bus: instruction memory read port plus instruction-register load port
//
// Signals:
//   mem_addr    fetch -> mem  read address, valid while mem_rd_en=1
//   mem_rd_en   fetch -> mem  one-cycle read request
//   mem_rdata   mem -> fetch  read data, valid while mem_valid=1
//   mem_valid   mem -> fetch  read response strobe
//   ir_write_en fetch -> IR   one-cycle load strobe
//   ir_data     fetch -> IR   fetched word, held until the next successful fetch
// Modports: master = fetch sequencer, slave = memory / instruction register side.
interface instr_fetch_if #(
  parameter int N  = 18,
  parameter int AW = 12
);
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic [N-1:0]  mem_rdata;
  logic          mem_valid;
  logic          ir_write_en;
  logic [N-1:0]  ir_data;

  modport master (
    output mem_addr, mem_rd_en, ir_write_en, ir_data,
    input  mem_rdata, mem_valid
  );

  modport slave (
    input  mem_addr, mem_rd_en, ir_write_en, ir_data,
    output mem_rdata, mem_valid
  );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch sequencer: PC, single-word memory read, IR load strobe
//
// Ports:
//   clk          rising-edge clock
//   rstn         asynchronous active-low reset
//   start        request one fetch (sampled in IDLE only)
//   pc_load_en   load pc from pc_load_val (IDLE only; the same-edge fetch uses the new value)
//   pc_load_val  jump target
//   bus          instr_fetch_if.master: memory read port and IR load port
//   pc           current program counter
//   busy         high whenever the sequencer is not IDLE
//   done         one-cycle pulse together with ir_write_en
//   fetch_err    one-cycle pulse when the memory fails to answer within TIMEOUT wait cycles
module instr_fetch #(
  parameter int            N        = 18,
  parameter int            AW       = 12,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int            TIMEOUT  = 15
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          pc_load_en,
  input  logic [AW-1:0] pc_load_val,
  instr_fetch_if.master bus,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic          fetch_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    LOAD = 2'd3
  } state_t;

  // Wait-cycle count at which the fetch gives up: the TIMEOUT-th WAIT cycle
  // without mem_valid is the last one.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t        state;
  logic [7:0]    wait_cnt;
  logic [AW-1:0] fetch_pc;

  // A jump and a start on the same edge fetch from the jump target.
  assign fetch_pc = pc_load_en ? pc_load_val : pc;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= IDLE;
      pc              <= RESET_PC;
      wait_cnt        <= '0;
      bus.ir_data     <= '0;
      bus.mem_addr    <= '0;
      bus.mem_rd_en   <= 1'b0;
      bus.ir_write_en <= 1'b0;
      done            <= 1'b0;
      fetch_err       <= 1'b0;
    end else begin
      // Strobes are single-cycle: default low, raised on entry to their state.
      bus.mem_addr    <= '0;
      bus.mem_rd_en   <= 1'b0;
      bus.ir_write_en <= 1'b0;
      done            <= 1'b0;
      fetch_err       <= 1'b0;

      case (state)
        IDLE: begin
          if (pc_load_en) begin
            pc <= pc_load_val;
          end
          if (start) begin
            state         <= ADDR;
            bus.mem_rd_en <= 1'b1;
            bus.mem_addr  <= fetch_pc;
          end
        end

        ADDR: begin
          state    <= WAIT;
          wait_cnt <= '0;
        end

        WAIT: begin
          // A response on the cycle the timeout would fire still counts.
          if (bus.mem_valid) begin
            bus.ir_data     <= bus.mem_rdata;
            bus.ir_write_en <= 1'b1;
            done            <= 1'b1;
            state           <= LOAD;
          end else if (wait_cnt == WAIT_LAST) begin
            fetch_err <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        LOAD: begin
          pc    <= pc + AW'(1);
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
